// File: rtl/ipml_fifo_framer_rd_v1_0_pkg.sv
// Shared types and constants for the FIFO read-side framer.
// State encoding, stall counter width and sample counter sizing.
package ipml_fifo_framer_rd_v1_0_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int STALL_W = 16;

  function automatic int samp_w(int frame_len);
    return (frame_len <= 2) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/ipml_fifo_framer_rd_v1_0_if.sv
// FIFO read port plus framed output stream bundle.
// master = framer side, slave = FIFO/downstream side.
interface ipml_fifo_framer_rd_v1_0_if #(
  parameter int DATA_W = 16,
  parameter int FIDX_W = 16
);

  logic [DATA_W-1:0] s_data;
  logic              s_vld;
  logic              s_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_vld;
  logic              m_ready;
  logic              m_sof;
  logic              m_eof;
  logic [FIDX_W-1:0] m_frame_idx;

  modport master (
    input  s_data, s_vld, m_ready,
    output s_rd_en, m_data, m_vld,
    output m_sof, m_eof, m_frame_idx
  );

  modport slave (
    output s_data, s_vld, m_ready,
    input  s_rd_en, m_data, m_vld,
    input  m_sof, m_eof, m_frame_idx
  );

endinterface

// File: rtl/ipml_framer_skid_v1_0.sv
// Two-entry register FIFO; output comes straight from the head register.
// in_ready depends only on registered occupancy.
module ipml_framer_skid_v1_0 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Entry storage: fill head first, spill to tail, shift tail up on pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (1'b1)
        push && (cnt_q == 2'd0):
          head_q <= in_data;
        push && (cnt_q == 2'd1) && pop:
          head_q <= in_data;
        push && (cnt_q == 2'd1) && !pop:
          tail_q <= in_data;
        pop && (cnt_q == 2'd2):
          head_q <= tail_q;
        default: ;
      endcase
    end
  end

  // Occupancy tracks pushes minus pops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/ipml_fifo_framer_rd_v1_0.sv
// Pops the prefetch FIFO and frames samples into FRAME_LEN beats
// tagged with sof/eof/frame index, decoupled by a 2-entry skid.
module ipml_fifo_framer_rd_v1_0
  import ipml_fifo_framer_rd_v1_0_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 512,
  parameter int FIDX_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  ipml_fifo_framer_rd_v1_0_if.master bus,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int SAMP_W = samp_w(FRAME_LEN);
  localparam int W      = DATA_W + 2 + FIDX_W;
  localparam logic [SAMP_W-1:0] LAST = SAMP_W'(FRAME_LEN - 1);

  state_t              state_q;
  state_t              state_d;
  logic [SAMP_W-1:0]   samp_q;
  logic [FIDX_W-1:0]   fidx_q;
  logic [STALL_W-1:0]  stall_q;
  logic                can_pop;
  logic                pop;
  logic                last;
  logic                in_ready;
  logic                out_valid;
  logic [W-1:0]        push_data;
  logic [W-1:0]        head;

  assign last      = (samp_q == LAST);
  assign push_data = {bus.s_data, (samp_q == '0), last, fidx_q};
  assign stall_cnt = stall_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter on first pop, leave only at a frame boundary
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (en && pop) state_d = S_RUN;
      S_RUN:  if (pop && last) state_d = en ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pop request gated by skid space and reset
  always_comb begin
    can_pop     = (state_q == S_RUN) || ((state_q == S_IDLE) && en);
    bus.s_rd_en = can_pop && in_ready && !rst;
    pop         = bus.s_rd_en && bus.s_vld;
    busy        = (state_q != S_IDLE) || out_valid;
  end

  // Sample position and frame index advance per pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
      fidx_q <= '0;
    end else if (pop) begin
      if (last) begin
        samp_q <= '0;
        fidx_q <= fidx_q + 1'b1;
      end else begin
        samp_q <= samp_q + 1'b1;
      end
    end
  end

  // Starved cycles while running, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && !bus.s_vld &&
                 in_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  ipml_framer_skid_v1_0 #(
    .W (W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (push_data),
    .in_valid  (pop),
    .in_ready  (in_ready),
    .out_data  (head),
    .out_valid (out_valid),
    .out_ready (bus.m_ready)
  );

  assign {bus.m_data, bus.m_sof, bus.m_eof, bus.m_frame_idx} = head;
  assign bus.m_vld = out_valid;

endmodule

// File: tb/tb_ipml_fifo_framer_rd_v1_0.sv
// Randomized scoreboard bench for the FIFO read framer.
// Expected beats derive from the global pop ordinal since reset.
module tb_ipml_fifo_framer_rd_v1_0;

  localparam int DW = 16;
  localparam int FL = 512;
  localparam int FW = 2;
  localparam int BW = DW + 2 + FW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        busy;
  logic [15:0] stall_cnt;

  ipml_fifo_framer_rd_v1_0_if #(.DATA_W(DW), .FIDX_W(FW)) bus ();

  ipml_fifo_framer_rd_v1_0 #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .FIDX_W    (FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  logic [BW-1:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int k = 0;
  int pops = 0;
  int en_drop_at = -1;
  int stall_at = -1;
  int stall_left = 0;
  int gap_pct = 0;
  int rdy_mode = 0;
  int beats = 0;
  int sof_seen = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(bit ok, string nm, longint act, longint req);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // FIFO model, handshake stimulus and reference model
  initial begin : drv
    bit pop_now;
    logic [DW-1:0] d;
    bus.s_vld = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b1;
    forever begin
      @(negedge clk);
      pop_now = !rst && bus.s_rd_en && bus.s_vld;
      @(posedge clk);
      #1;
      if (pop_now && !rst && fifo_q.size() > 0) begin
        d = fifo_q.pop_front();
        exp_q.push_back({d, (k % FL) == 0, (k % FL) == FL - 1,
                         FW'((k / FL) % 4)});
        k++;
        pops++;
        if (pops == en_drop_at) en = 1'b0;
        if (pops == stall_at) stall_left = 7;
      end
      if (stall_left > 0) begin
        bus.s_vld = 1'b0;
        stall_left--;
      end else if (gap_pct > 0 &&
                   $urandom_range(99) < gap_pct) begin
        bus.s_vld = 1'b0;
      end else begin
        bus.s_vld = (fifo_q.size() > 0);
      end
      bus.s_data = (fifo_q.size() > 0) ? fifo_q[0] : DW'($urandom);
      case (rdy_mode)
        1: bus.m_ready = ~bus.m_ready;
        2: bus.m_ready = ($urandom_range(99) < 60);
        default: bus.m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: ordering, content, stability and outstanding depth
  initial begin : mon
    bit hold = 0;
    logic [BW-1:0] held = '0;
    logic [BW-1:0] cur;
    logic [BW-1:0] e;
    forever begin
      @(negedge clk);
      cur = {bus.m_data, bus.m_sof, bus.m_eof, bus.m_frame_idx};
      if (rst) begin
        hold = 0;
      end else begin
        if (hold) chk(bus.m_vld && cur == held, "stable", cur, held);
        if (exp_q.size() > 2) chk(0, "outstanding", exp_q.size(), 2);
        if (bus.m_vld && bus.m_ready) begin
          beats++;
          if (bus.m_sof) sof_seen++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_beat", cur, 0);
          end else begin
            e = exp_q.pop_front();
            chk(cur == e, "beat", cur, e);
          end
        end
        hold = bus.m_vld && !bus.m_ready;
        held = cur;
      end
    end
  end

  task automatic clr_model();
    fifo_q.delete();
    exp_q.delete();
    k = 0;
    pops = 0;
    stall_left = 0;
    en_drop_at = -1;
    stall_at = -1;
    beats = 0;
    sof_seen = 0;
    first_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    en = 1'b0;
    clr_model();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic load(int n, bit ramp);
    for (int i = 0; i < n; i++)
      fifo_q.push_back(ramp ? DW'(i) : DW'($urandom));
  endtask

  task automatic drain(int target, string nm);
    int n = 0;
    while (!(pops >= target && exp_q.size() == 0 && !busy) &&
           n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 20000, {nm, "_timeout"}, n, 20000);
    chk(pops == target, {nm, "_pops"}, pops, target);
  endtask

  initial begin : scen
    int n;
    do_reset();
    @(negedge clk);
    chk(bus.m_vld == 0, "rst_m_vld", bus.m_vld, 0);
    chk(bus.s_rd_en == 0, "rst_rd_en", bus.s_rd_en, 0);
    chk(busy == 0, "rst_busy", busy, 0);
    chk(stall_cnt == 0, "rst_stall", stall_cnt, 0);
    chk({bus.m_data, bus.m_sof, bus.m_eof, bus.m_frame_idx} == 0,
        "rst_m_bus", bus.m_data, 0);

    // Ramp of two frames, always ready
    @(posedge clk);
    #2;
    load(1024, 1);
    en_drop_at = 513;
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.s_rd_en && bus.s_vld) && n < 100);
    chk(n < 100, "first_pop_timeout", n, 100);
    chk(bus.m_vld == 0, "lat_before", bus.m_vld, 0);
    @(negedge clk);
    chk(bus.m_vld == 1, "lat_after", bus.m_vld, 1);
    drain(1024, "ramp");
    chk(last_cyc - first_cyc == 1023, "b2b_span",
        last_cyc - first_cyc, 1023);
    chk(sof_seen == 2, "ramp_sofs", sof_seen, 2);

    // Toggling ready
    do_reset();
    rdy_mode = 1;
    load(1024, 0);
    en_drop_at = 513;
    en = 1'b1;
    drain(1024, "toggle");
    chk(beats == 1024, "toggle_beats", beats, 1024);
    rdy_mode = 0;

    // en dropped after sample 100 of frame 0
    do_reset();
    load(1024, 1);
    en_drop_at = 101;
    en = 1'b1;
    drain(512, "en_drop");
    repeat (20) @(negedge clk);
    chk(pops == 512, "no_frame1", pops, 512);
    chk(bus.s_rd_en == 0, "drop_rd_en", bus.s_rd_en, 0);
    chk(busy == 0, "drop_busy", busy, 0);
    chk(fifo_q.size() == 512, "drop_left", fifo_q.size(), 512);

    // Seven starved cycles at sample 300
    do_reset();
    load(512, 0);
    en_drop_at = 1;
    stall_at = 300;
    en = 1'b1;
    drain(512, "stall");
    chk(stall_cnt == 7, "stall_cnt", stall_cnt, 7);

    // Reset mid-frame at sample 200
    do_reset();
    load(512, 0);
    en = 1'b1;
    n = 0;
    while (pops < 200 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 1000, "mid_rst_timeout", n, 1000);
    #2;
    rst = 1'b1;
    clr_model();
    @(negedge clk);
    chk(bus.m_vld == 0, "midrst_m_vld", bus.m_vld, 0);
    chk(bus.s_rd_en == 0, "midrst_rd_en", bus.s_rd_en, 0);
    chk(busy == 0, "midrst_busy", busy, 0);
    chk({bus.m_data, bus.m_sof, bus.m_eof, bus.m_frame_idx} == 0,
        "midrst_m_bus", bus.m_data, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    load(512, 0);
    en_drop_at = 1;
    drain(512, "post_rst");
    chk(sof_seen == 1, "post_rst_sof", sof_seen, 1);

    // Five frames with 2-bit index, random gaps and backpressure
    do_reset();
    gap_pct = 20;
    rdy_mode = 2;
    load(5 * FL, 0);
    en_drop_at = 4 * FL + 1;
    en = 1'b1;
    drain(5 * FL, "idx_wrap");
    chk(sof_seen == 5, "idx_sofs", sof_seen, 5);
    gap_pct = 0;
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
